multicycle_control_unit: RTL and testbench

//  Multi-cycle RV32I control FSM: the producer side of the 4-bit ALU-op interface.

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/multicycle_control_unit_if.sv | 45 ++++
 rtl/alu_op_decoder.sv | 51 +++++
 rtl/multicycle_control_unit.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit.
// ALU op codes, opcodes, FSM states and datapath mux selects.
package ctrl_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_RA  = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_LS  = 4'b0110;
  localparam logic [3:0] ALU_RS  = 4'b0111;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  localparam logic [3:0] ALU_NEQ = 4'b1001;
  localparam logic [3:0] ALU_LT  = 4'b1010;
  localparam logic [3:0] ALU_LTS = 4'b1011;
  localparam logic [3:0] ALU_GE  = 4'b1100;
  localparam logic [3:0] ALU_GES = 4'b1101;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALWB    = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_R   = 2'd1,
    CLS_I   = 2'd2,
    CLS_BR  = 2'd3
  } alu_class_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the instruction register / datapath
// and the multi-cycle control FSM.
interface multicycle_control_unit_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       alu_result_lsb;
  logic       mem_ready;
  logic [3:0] aluControl;
  logic [1:0] alu_src_a_sel;
  logic [1:0] alu_src_b_sel;
  logic [1:0] result_sel;
  logic       adr_src;
  logic       mem_req;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7b5,
    input  alu_result_lsb, mem_ready,
    output aluControl,
    output alu_src_a_sel, alu_src_b_sel,
    output result_sel, adr_src,
    output mem_req, mem_write,
    output ir_write, pc_write, reg_write,
    output instr_done, illegal
  );

  modport slave (
    output opcode, funct3, funct7b5,
    output alu_result_lsb, mem_ready,
    input  aluControl,
    input  alu_src_a_sel, alu_src_b_sel,
    input  result_sel, adr_src,
    input  mem_req, mem_write,
    input  ir_write, pc_write, reg_write,
    input  instr_done, illegal
  );

endinterface

// File: rtl/alu_op_decoder.sv
// Maps {class, funct3, funct7b5} to the 4-bit ALU op.
// bad_funct3 flags the two unused branch encodings.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  alu_class_t cls,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_op,
  output logic       bad_funct3
);

  logic is_rr;
  logic is_br;

  assign is_rr = (cls == CLS_R) || (cls == CLS_I);
  assign is_br = (cls == CLS_BR);

  always_comb begin
    alu_op     = ALU_ADD;
    bad_funct3 = 1'b0;
    unique case (1'b1)
      is_rr: begin
        unique case (funct3)
          3'b000: alu_op = (cls == CLS_R && funct7b5)
                           ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_LS;
          3'b010: alu_op = ALU_LTS;
          3'b011: alu_op = ALU_LT;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = funct7b5 ? ALU_RA : ALU_RS;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
        endcase
      end
      is_br: begin
        case (funct3)
          3'b000:  alu_op = ALU_EQ;
          3'b001:  alu_op = ALU_NEQ;
          3'b100:  alu_op = ALU_LTS;
          3'b101:  alu_op = ALU_GES;
          3'b110:  alu_op = ALU_LT;
          3'b111:  alu_op = ALU_GE;
          default: bad_funct3 = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences each instruction and
// drives ALU op, datapath mux selects and write enables.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_unit_if.master   bus
);

  state_t     state_q, state_d;
  alu_class_t cls;
  logic [3:0] dec_op;
  logic       bad_f3;

  logic [1:0] a_sel, b_sel, res_sel;
  logic       adr, req, we, irw, pcw;
  logic       rw, done, ill;

  always_comb begin
    cls = CLS_ADD;
    case (state_q)
      S_EXEC_R: cls = CLS_R;
      S_EXEC_I: cls = CLS_I;
      S_BRANCH: cls = CLS_BR;
      default:  cls = CLS_ADD;
    endcase
  end

  alu_op_decoder u_dec (
    .cls        (cls),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .alu_op     (dec_op),
    .bad_funct3 (bad_f3)
  );

  always_comb begin
    state_d = state_q;
    a_sel   = SRCA_PC;
    b_sel   = SRCB_REGB;
    res_sel = RES_ALUOUT;
    adr     = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    irw     = 1'b0;
    pcw     = 1'b0;
    rw      = 1'b0;
    done    = 1'b0;
    ill     = 1'b0;
    case (state_q)
      S_FETCH: begin
        b_sel   = SRCB_FOUR;
        res_sel = RES_ALU;
        req     = 1'b1;
        if (bus.mem_ready) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_sel = SRCA_OLDPC;
        b_sel = SRCB_IMM;
        case (bus.opcode)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_R:      state_d = S_EXEC_R;
          OP_I:      state_d = S_EXEC_I;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_AUIPC;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        a_sel   = SRCA_REGA;
        b_sel   = SRCB_IMM;
        state_d = (bus.opcode == OP_STORE)
                  ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr = 1'b1;
        req = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_sel = RES_MEM;
        rw      = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        adr = 1'b1;
        req = 1'b1;
        we  = 1'b1;
        // completion is only known once the store is accepted
        if (bus.mem_ready) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        a_sel   = SRCA_REGA;
        state_d = S_ALUWB;
      end
      S_EXEC_I, S_LUI: begin
        a_sel   = SRCA_REGA;
        b_sel   = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        a_sel   = SRCA_OLDPC;
        b_sel   = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw      = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        a_sel = SRCA_REGA;
        if (bad_f3) begin
          state_d = S_TRAP;
        end else begin
          pcw     = bus.alu_result_lsb;
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_JAL: begin
        a_sel   = SRCA_OLDPC;
        b_sel   = SRCB_FOUR;
        pcw     = 1'b1;
        state_d = S_JALWB;
      end
      S_JALR: begin
        a_sel   = SRCA_REGA;
        b_sel   = SRCB_IMM;
        res_sel = RES_ALU;
        pcw     = 1'b1;
        state_d = S_JALWB;
      end
      S_JALWB: begin
        a_sel   = SRCA_OLDPC;
        b_sel   = SRCB_FOUR;
        res_sel = RES_ALU;
        rw      = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        ill     = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= state_t'(RESET_STATE);
    else       state_q <= state_d;
  end

  // reset gates every output so an in-flight access drops at once
  assign bus.aluControl    = reset ? ALU_ADD : dec_op;
  assign bus.alu_src_a_sel = reset ? 2'b00 : a_sel;
  assign bus.alu_src_b_sel = reset ? 2'b00 : b_sel;
  assign bus.result_sel    = reset ? 2'b00 : res_sel;
  assign bus.adr_src       = adr  & ~reset;
  assign bus.mem_req       = req  & ~reset;
  assign bus.mem_write     = we   & ~reset;
  assign bus.ir_write      = irw  & ~reset;
  assign bus.pc_write      = pcw  & ~reset;
  assign bus.reg_write     = rw   & ~reset;
  assign bus.instr_done    = done & ~reset;
  assign bus.illegal       = ill  & ~reset;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected
// output vectors go through a scoreboard queue and are checked.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_control_unit_if bus();

  multicycle_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [3:0] A_ADD = 4'b0000;
  localparam logic [3:0] A_SUB = 4'b0001;
  localparam logic [3:0] A_RA  = 4'b0011;
  localparam logic [3:0] A_LTS = 4'b1011;

  logic [17:0] exp_q[$];
  logic [17:0] msk_q[$];
  string       tag_q[$];

  wire logic [17:0] obs = {
    bus.aluControl, bus.alu_src_a_sel,
    bus.alu_src_b_sel, bus.result_sel,
    bus.adr_src, bus.mem_req, bus.mem_write,
    bus.ir_write, bus.pc_write, bus.reg_write,
    bus.instr_done, bus.illegal};

  // en = {adr_src,mem_req,mem_write,ir_write,
  //       pc_write,reg_write,instr_done,illegal}
  function automatic logic [17:0] v(
    input logic [3:0] al, input logic [1:0] a,
    input logic [1:0] b, input logic [1:0] r,
    input logic [7:0] en);
    return {al, a, b, r, en};
  endfunction

  function automatic logic [17:0] m(
    input logic cal, input logic ca, input logic cb,
    input logic cr, input logic cadr);
    return {{4{cal}}, {2{ca}}, {2{cb}}, {2{cr}},
            cadr, 7'h7f};
  endfunction

  function automatic logic [17:0] fv(input logic rdy);
    return v(A_ADD, 2'b00, 2'b10, 2'b10,
             {3'b010, rdy, rdy, 3'b000});
  endfunction

  task automatic compare();
    logic [17:0] e, k;
    string t;
    checks++;
    assert (exp_q.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard_empty obs=%h", obs);
      return;
    end
    e = exp_q.pop_front();
    k = msk_q.pop_front();
    t = tag_q.pop_front();
    assert ((obs & k) === (e & k)) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h mask=%h",
             t, obs & k, e & k, k);
    end
  endtask

  task automatic push(input string t,
    input logic [17:0] e, input logic [17:0] k);
    exp_q.push_back(e);
    msk_q.push_back(k);
    tag_q.push_back(t);
  endtask

  task automatic step(input string t,
    input logic [17:0] e, input logic [17:0] k);
    push(t, e, k);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic now(input string t,
    input logic [17:0] e, input logic [17:0] k);
    push(t, e, k);
    #1;
    compare();
  endtask

  task automatic st_fetch(input logic rdy);
    bus.mem_ready = rdy;
    step("fetch", fv(rdy), m(1, 1, 1, 1, 1));
  endtask

  task automatic st_decode();
    step("decode", v(A_ADD, 2'b01, 2'b01, 2'b00, 8'h00),
         m(1, 1, 1, 0, 0));
  endtask

  task automatic st_memadr();
    step("memadr", v(A_ADD, 2'b10, 2'b01, 2'b00, 8'h00),
         m(1, 1, 1, 0, 0));
  endtask

  task automatic st_memread(input logic rdy);
    bus.mem_ready = rdy;
    step("memread", v(A_ADD, 2'b00, 2'b00, 2'b00, 8'hc0),
         m(1, 0, 0, 0, 1));
  endtask

  task automatic st_memwb();
    step("memwb", v(A_ADD, 2'b00, 2'b00, 2'b01, 8'h06),
         m(1, 0, 0, 1, 0));
  endtask

  task automatic st_memwrite(input logic rdy);
    bus.mem_ready = rdy;
    step("memwrite", v(A_ADD, 2'b00, 2'b00, 2'b00,
         {6'b111000, rdy, 1'b0}), m(1, 0, 0, 0, 1));
  endtask

  task automatic st_exec(input string t,
    input logic [3:0] al, input logic [1:0] bs);
    step(t, v(al, 2'b10, bs, 2'b00, 8'h00),
         m(1, 1, 1, 0, 0));
  endtask

  task automatic st_aluwb();
    step("aluwb", v(A_ADD, 2'b00, 2'b00, 2'b00, 8'h06),
         m(1, 0, 0, 1, 0));
  endtask

  task automatic st_branch(input logic [3:0] al,
    input logic lsb);
    bus.alu_result_lsb = lsb;
    step("branch", v(al, 2'b10, 2'b00, 2'b00,
         {4'b0000, lsb, 3'b010}), m(1, 1, 1, 1, 0));
  endtask

  task automatic st_trap(input string t);
    bus.mem_ready = 1'b1;
    bus.alu_result_lsb = 1'b1;
    step(t, v(A_ADD, 2'b00, 2'b00, 2'b00, 8'h01),
         m(0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_ins(input logic [6:0] op,
    input logic [2:0] f3, input logic f7);
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
  endtask

  initial begin
    reset = 1'b1;
    set_ins(7'h00, 3'b000, 1'b0);
    bus.alu_result_lsb = 1'b0;
    bus.mem_ready      = 1'b0;
    #2;
    now("reset_vals", 18'h0, m(1, 1, 1, 1, 1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    now("release_fetch", fv(1'b0), m(1, 1, 1, 1, 1));
    st_fetch(1'b0);

    set_ins(7'b0110011, 3'b000, 1'b1);
    st_fetch(1'b1);
    st_decode();
    st_exec("exec_r_sub", A_SUB, 2'b00);
    st_aluwb();

    set_ins(7'b0010011, 3'b101, 1'b1);
    st_fetch(1'b1);
    st_decode();
    st_exec("exec_i_srai", A_RA, 2'b01);
    st_aluwb();

    set_ins(7'b0010011, 3'b000, 1'b1);
    st_fetch(1'b1);
    st_decode();
    st_exec("exec_i_addi", A_ADD, 2'b01);
    st_aluwb();

    set_ins(7'b0000011, 3'b010, 1'b0);
    st_fetch(1'b1);
    st_decode();
    st_memadr();
    st_memread(1'b0);
    st_memread(1'b0);
    st_memread(1'b0);
    st_memread(1'b1);
    st_memwb();

    set_ins(7'b0100011, 3'b010, 1'b0);
    st_fetch(1'b0);
    st_fetch(1'b1);
    st_decode();
    st_memadr();
    st_memwrite(1'b0);
    st_memwrite(1'b1);

    set_ins(7'b1100011, 3'b100, 1'b0);
    st_fetch(1'b1);
    st_decode();
    st_branch(A_LTS, 1'b1);
    st_fetch(1'b1);
    st_decode();
    st_branch(A_LTS, 1'b0);

    set_ins(7'b1101111, 3'b000, 1'b0);
    st_fetch(1'b1);
    st_decode();
    step("jal", v(A_ADD, 2'b01, 2'b10, 2'b00, 8'h08),
         m(1, 1, 1, 1, 0));
    step("jalwb", v(A_ADD, 2'b01, 2'b10, 2'b10, 8'h06),
         m(1, 1, 1, 1, 0));

    set_ins(7'b1100111, 3'b000, 1'b0);
    st_fetch(1'b1);
    st_decode();
    step("jalr", v(A_ADD, 2'b10, 2'b01, 2'b10, 8'h08),
         m(1, 1, 1, 1, 0));
    step("jalwb", v(A_ADD, 2'b01, 2'b10, 2'b10, 8'h06),
         m(1, 1, 1, 1, 0));

    set_ins(7'b0110111, 3'b000, 1'b0);
    st_fetch(1'b1);
    st_decode();
    step("lui", v(A_ADD, 2'b00, 2'b01, 2'b00, 8'h00),
         m(1, 0, 1, 0, 0));
    st_aluwb();

    set_ins(7'b0010111, 3'b000, 1'b0);
    st_fetch(1'b1);
    st_decode();
    step("auipc", v(A_ADD, 2'b01, 2'b01, 2'b00, 8'h00),
         m(1, 1, 1, 0, 0));
    st_aluwb();

    set_ins(7'b0000011, 3'b000, 1'b0);
    st_fetch(1'b1);
    st_decode();
    st_memadr();
    st_memread(1'b0);
    #1;
    reset = 1'b1;
    now("reset_mid_memread", 18'h0, m(1, 1, 1, 1, 1));
    step("reset_held", 18'h0, m(1, 1, 1, 1, 1));
    reset = 1'b0;
    now("release_fetch2", fv(1'b0), m(1, 1, 1, 1, 1));

    set_ins(7'b1111111, 3'b000, 1'b0);
    st_fetch(1'b1);
    st_decode();
    st_trap("trap_opcode");
    st_trap("trap_sticky1");
    st_trap("trap_sticky2");
    do_reset();

    set_ins(7'b1100011, 3'b010, 1'b0);
    st_fetch(1'b1);
    st_decode();
    bus.alu_result_lsb = 1'b1;
    step("branch_bad", v(A_ADD, 2'b00, 2'b00, 2'b00, 8'h00),
         m(0, 0, 0, 0, 0));
    st_trap("trap_branch");
    st_trap("trap_branch_sticky");
    do_reset();
    now("after_reset", fv(1'b0), m(1, 1, 1, 1, 1));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
